bcd_convert_scheduler: RTL and testbench

Time-shared sequential binary-to-BCD conversion engine for the on-screen numeric readouts (score, timer, height, and similar). Up to NUM_REQ requesters flag that their signed binary value changed. A round-robin scheduler grants one slot at a time to a single iterative double-dabble datapath, which performs one shift/add-3 step per cycle. Converted digits and signs sit in registered per-slot banks that the BCD sequence display controllers read every pixel, so display logic never carries a combinational converter.

---
 rtl/bcd_convert_scheduler_if.sv | 27 ++
 rtl/bcd_convert_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_bcd_convert_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_scheduler_if.sv
// Request/result bundle for the time-shared binary-to-BCD engine.
// The scheduler is the slave; whoever produces values and reads digits is the master.
interface bcd_convert_scheduler_if #(
    parameter int NUM_REQ   = 3,
    parameter int BIN_WIDTH = 20,
    parameter int DIGITS    = 6
) ();
    logic                            frame_start;
    logic [NUM_REQ-1:0]              update_req;
    logic [NUM_REQ*BIN_WIDTH-1:0]    bin_in;
    logic [NUM_REQ*DIGITS*4-1:0]     bcd_out;
    logic [NUM_REQ-1:0]              neg_out;
    logic [NUM_REQ-1:0]              bcd_valid;
    logic                            busy;
    logic                            done;
    logic [$clog2(NUM_REQ)-1:0]      done_id;

    modport master (
        output frame_start, update_req, bin_in,
        input  bcd_out, neg_out, bcd_valid, busy, done, done_id
    );

    modport slave (
        input  frame_start, update_req, bin_in,
        output bcd_out, neg_out, bcd_valid, busy, done, done_id
    );
endinterface

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler feeding one iterative double-dabble converter;
// results land in registered per-slot digit/sign banks for the display readouts.
module bcd_convert_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int BIN_WIDTH = 20,
    parameter int DIGITS    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_convert_scheduler_if.slave  bus
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int ACC_W = DIGITS * 4;
    localparam int ITW   = $clog2(BIN_WIDTH);
    localparam int SH_W  = ACC_W + BIN_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int n = 0; n < DIGITS; n++) begin
            r[n*4 +: 4] = (a[n*4 +: 4] >= 4'd5) ? (a[n*4 +: 4] + 4'd3) : a[n*4 +: 4];
        end
        return r;
    endfunction

    // The most negative input wraps back onto itself, which is exactly 2^(BIN_WIDTH-1) unsigned.
    function automatic logic [BIN_WIDTH-1:0] abs_mag(input logic [BIN_WIDTH-1:0] v);
        return v[BIN_WIDTH-1] ? (~v + BIN_WIDTH'(1)) : v;
    endfunction

    state_t                      state_q, state_d;
    logic [NUM_REQ-1:0]          pending_q, pending_d;
    logic [IDW-1:0]              last_gnt_q;
    logic [IDW-1:0]              gnt_q;
    logic                        neg_q;
    logic [BIN_WIDTH-1:0]        mag_q;
    logic [ACC_W-1:0]            acc_q;
    logic [ITW-1:0]              iter_q;
    logic [NUM_REQ*ACC_W-1:0]    bcd_q;
    logic [NUM_REQ-1:0]          neg_out_q;
    logic [NUM_REQ-1:0]          valid_q;
    logic                        busy_q;
    logic                        done_q;
    logic [IDW-1:0]              done_id_q;

    logic                        pick_found_s;
    logic [IDW-1:0]              pick_id_s;
    int                          cand_s;
    logic                        grant_s;
    logic [NUM_REQ-1:0]          gnt_mask_s;
    logic [BIN_WIDTH-1:0]        slot_val_s;
    logic [SH_W-1:0]             shift_s;

    // Round-robin pick: highest k written first so the nearest slot after last_gnt wins.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        cand_s       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s       = (int'(last_gnt_q) + k) % NUM_REQ;
            pick_id_s    = pending_q[IDW'(cand_s)] ? IDW'(cand_s) : pick_id_s;
            pick_found_s = pick_found_s | pending_q[IDW'(cand_s)];
        end
    end

    // Operand mux for the slot being granted.
    always_comb begin
        slot_val_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_val_s = (pick_id_s == IDW'(i)) ? bus.bin_in[i*BIN_WIDTH +: BIN_WIDTH] : slot_val_s;
        end
    end

    // FSM next-state and grant decision.
    always_comb begin
        state_d = state_q;
        grant_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d = SHIFT;
                    grant_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (iter_q == ITW'(BIN_WIDTH - 1)) begin
                    state_d = COMMIT;
                end else begin
                    state_d = SHIFT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending bookkeeping; a new request on the grant edge survives the clear.
    always_comb begin
        gnt_mask_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_mask_s[i] = grant_s & (pick_id_s == IDW'(i));
        end
        pending_d = (pending_q & ~gnt_mask_s) | bus.update_req | {NUM_REQ{bus.frame_start}};
        shift_s   = {add3(acc_q), mag_q};
    end

    // Control state, pending flags and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            last_gnt_q <= IDW'(NUM_REQ - 1);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            busy_q     <= (state_d != IDLE);
            if (grant_s) begin
                last_gnt_q <= pick_id_s;
            end
        end
    end

    // Double-dabble datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            neg_q  <= 1'b0;
            mag_q  <= '0;
            acc_q  <= '0;
            iter_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_s) begin
                        gnt_q  <= pick_id_s;
                        neg_q  <= slot_val_s[BIN_WIDTH-1];
                        mag_q  <= abs_mag(slot_val_s);
                        acc_q  <= '0;
                        iter_q <= '0;
                    end
                end
                SHIFT: begin
                    acc_q  <= shift_s[SH_W-2 -: ACC_W];
                    mag_q  <= {shift_s[BIN_WIDTH-2:0], 1'b0};
                    iter_q <= iter_q + ITW'(1);
                end
                default: begin
                    iter_q <= iter_q;
                end
            endcase
        end
    end

    // Result banks: only the granted slot is written, and only in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= '0;
            neg_out_q <= '0;
            valid_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == COMMIT) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt_q == IDW'(i)) begin
                        bcd_q[i*ACC_W +: ACC_W] <= acc_q;
                        neg_out_q[i]            <= neg_q;
                        valid_q[i]              <= 1'b1;
                    end
                end
                done_q    <= 1'b1;
                done_id_q <= gnt_q;
            end
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.neg_out   = neg_out_q;
    assign bus.bcd_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed bench for bcd_convert_scheduler: reset, signed conversions, frame sweep,
// round-robin ordering with an in-flight re-request, and reset mid-conversion.
module tb_bcd_convert_scheduler;
    localparam int NUM_REQ   = 3;
    localparam int BIN_WIDTH = 20;
    localparam int DIGITS    = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bcd_convert_scheduler_if #(.NUM_REQ(NUM_REQ), .BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_convert_scheduler #(.NUM_REQ(NUM_REQ), .BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] slot_bcd(input int i);
        return bus.bcd_out[i*24 +: 24];
    endfunction

    task automatic set_bin(input int i, input logic [19:0] v);
        bus.bin_in[i*20 +: 20] = v;
    endtask

    task automatic pulse_req(input logic [2:0] m);
        @(negedge clk);
        bus.update_req = m;
        @(negedge clk);
        bus.update_req = 3'b000;
    endtask

    // Waits (bounded) for done, then checks latency (if exp_lat > 0), id, digits and sign.
    task automatic conv_check(input string tag, input int id, input logic [23:0] exp_bcd,
                              input logic exp_neg, input int exp_lat);
        int c;
        bit seen;
        seen = 1'b0;
        for (c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 128'(seen), 128'(1'b1));
        if (exp_lat > 0) check({tag, "_latency"}, 128'(c), 128'(exp_lat));
        check({tag, "_id"},  128'(bus.done_id), 128'(id));
        check({tag, "_bcd"}, 128'(slot_bcd(id)), 128'(exp_bcd));
        check({tag, "_neg"}, 128'(bus.neg_out[id]), 128'(exp_neg));
    endtask

    initial begin
        int dones;
        rst_n          = 1'b0;
        bus.frame_start = 1'b0;
        bus.update_req  = 3'b000;
        bus.bin_in      = '0;

        // Reset held with inputs toggling.
        repeat (2) @(negedge clk);
        bus.frame_start = 1'b1;
        bus.update_req  = 3'b111;
        set_bin(1, 20'd5);
        repeat (2) @(negedge clk);
        check("rst_bcd",   128'(bus.bcd_out),   128'(72'h0));
        check("rst_neg",   128'(bus.neg_out),   128'(3'b000));
        check("rst_valid", 128'(bus.bcd_valid), 128'(3'b000));
        check("rst_busy",  128'(bus.busy),      128'(1'b0));
        check("rst_done",  128'(bus.done),      128'(1'b0));
        check("rst_id",    128'(bus.done_id),   128'(2'd0));
        bus.frame_start = 1'b0;
        bus.update_req  = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy",  128'(bus.busy),      128'(1'b0));
        check("idle_valid", 128'(bus.bcd_valid), 128'(3'b000));
        check("idle_done",  128'(bus.done),      128'(1'b0));

        // Single conversion; busy one cycle after the pulse, commit 21 cycles later.
        set_bin(1, 20'd12345);
        pulse_req(3'b010);
        @(negedge clk);
        check("t1_busy_on", 128'(bus.busy), 128'(1'b1));
        conv_check("t1", 1, 24'h012345, 1'b0, 21);
        check("t1_busy_off", 128'(bus.busy),      128'(1'b0));
        check("t1_valid",    128'(bus.bcd_valid), 128'(3'b010));
        @(negedge clk);
        check("t1_done_clr", 128'(bus.done),    128'(1'b0));
        check("t1_id_hold",  128'(bus.done_id), 128'(2'd1));

        // Signed values on slot 0.
        set_bin(0, 20'hFFC25);
        pulse_req(3'b001);
        conv_check("neg987", 0, 24'h000987, 1'b1, 22);
        check("slot1_kept", 128'(slot_bcd(1)), 128'(24'h012345));
        set_bin(0, 20'h80000);
        pulse_req(3'b001);
        conv_check("minneg", 0, 24'h524288, 1'b1, 22);
        set_bin(0, 20'h00000);
        pulse_req(3'b001);
        conv_check("zero", 0, 24'h000000, 1'b0, 22);
        set_bin(2, 20'd42);
        pulse_req(3'b100);
        conv_check("s2_42", 2, 24'h000042, 1'b0, 22);

        // Frame sweep from last_gnt = 2: order 0, 1, 2 at 22-cycle spacing.
        set_bin(0, 20'd7);
        set_bin(1, 20'd99999);
        set_bin(2, 20'hFFFFF);
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        conv_check("fr0", 0, 24'h000007, 1'b0, 22);
        conv_check("fr1", 1, 24'h099999, 1'b0, 22);
        conv_check("fr2", 2, 24'h000001, 1'b1, 22);
        check("fr_neg",   128'(bus.neg_out),   128'(3'b100));
        check("fr_valid", 128'(bus.bcd_valid), 128'(3'b111));

        // Round-robin after slot 1, plus a re-request of slot 2 while it is in flight.
        set_bin(1, 20'd333);
        pulse_req(3'b010);
        repeat (3) @(negedge clk);
        set_bin(0, 20'd111);
        set_bin(2, 20'd222);
        pulse_req(3'b101);
        conv_check("rr1", 1, 24'h000333, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("rr2_busy", 128'(bus.busy), 128'(1'b1));
        set_bin(2, 20'd555);
        pulse_req(3'b100);
        conv_check("rr2", 2, 24'h000222, 1'b0, 0);
        conv_check("rr0", 0, 24'h000111, 1'b0, 22);
        conv_check("rr2b", 2, 24'h000555, 1'b0, 22);

        // Asynchronous reset mid-SHIFT abandons the conversion.
        set_bin(0, 20'd777);
        pulse_req(3'b001);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_bcd",   128'(bus.bcd_out),   128'(72'h0));
        check("mid_neg",   128'(bus.neg_out),   128'(3'b000));
        check("mid_valid", 128'(bus.bcd_valid), 128'(3'b000));
        check("mid_busy",  128'(bus.busy),      128'(1'b0));
        check("mid_done",  128'(bus.done),      128'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("mid_no_done", 128'(dones),         128'(0));
        check("mid_idle",    128'(bus.busy),      128'(1'b0));
        check("mid_bcd0",    128'(slot_bcd(0)),   128'(24'h000000));
        set_bin(1, 20'd8);
        pulse_req(3'b010);
        conv_check("post", 1, 24'h000008, 1'b0, 22);
        check("post_valid", 128'(bus.bcd_valid), 128'(3'b010));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
